// File: rtl/video_pkg.sv
// Shared video definitions for the pixel pipeline.
//   - resolution and pattern code enums
//   - per-resolution active width/height and colour-bar width
//   - 24-bit {R,G,B} colour constants and the colour-bar lookup
package video_pkg;

  typedef enum logic [1:0] {
    RES_640  = 2'd0,
    RES_1920 = 2'd1,
    RES_1280 = 2'd2,
    RES_ALT  = 2'd3   // treated as 640x480
  } res_e;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_BOX   = 2'd2,
    PAT_GRID  = 2'd3
  } pat_e;

  localparam logic [23:0] WHITE     = 24'hFFFFFF;
  localparam logic [23:0] YELLOW    = 24'hFFFF00;
  localparam logic [23:0] CYAN      = 24'h00FFFF;
  localparam logic [23:0] GREEN     = 24'h00FF00;
  localparam logic [23:0] MAGENTA   = 24'hFF00FF;
  localparam logic [23:0] RED       = 24'hFF0000;
  localparam logic [23:0] BLUE      = 24'h0000FF;
  localparam logic [23:0] BLACK     = 24'h000000;
  localparam logic [23:0] BOX_BG    = 24'h000080;
  localparam logic [23:0] DARK_GREY = 24'h202020;

  function automatic logic [10:0] act_w(input logic [1:0] res);
    case (res_e'(res))
      RES_1920: return 11'd1920;
      RES_1280: return 11'd1280;
      default:  return 11'd640;
    endcase
  endfunction

  function automatic logic [10:0] act_h(input logic [1:0] res);
    case (res_e'(res))
      RES_1920: return 11'd1080;
      RES_1280: return 11'd720;
      default:  return 11'd480;
    endcase
  endfunction

  function automatic logic [7:0] bar_w(input logic [1:0] res);
    case (res_e'(res))
      RES_1920: return 8'd240;
      RES_1280: return 8'd160;
      default:  return 8'd80;
    endcase
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return MAGENTA;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/box_mover.sv
// Bouncing-box position tracker.
//   clk_pix, rst_pix : pixel clock, async active-high reset
//   tick             : one-cycle frame tick; the only time state moves
//   res              : resolution code, sampled at each tick
//   bx, by           : box top-left corner
// A change of res between ticks re-homes the box instead of moving it.
module box_mover
  import video_pkg::*;
#(
  parameter int BOX_SIZE  = 64,
  parameter int BOX_SPEED = 2
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic        tick,
  input  logic [1:0]  res,
  output logic [10:0] bx,
  output logic [10:0] by
);

  typedef enum logic {DIR_DEC = 1'b0, DIR_INC = 1'b1} dir_e;

  logic [10:0] r_bx, r_by, w_bx_nxt, w_by_nxt;
  dir_e        r_dx, r_dy, w_dx_nxt, w_dy_nxt;
  logic [1:0]  r_res, w_res_nxt;
  logic [11:0] w_x_step, w_y_step;

  // Returns {new_dir, new_pos} for one axis against the limit lim.
  function automatic logic [11:0] step(input logic [10:0] pos, input dir_e dir,
                                       input logic [10:0] lim);
    logic [12:0] far;
    if (dir == DIR_INC) begin
      far = {2'b00, pos} + 13'(BOX_SPEED) + 13'(BOX_SIZE);
      if (far >= {2'b00, lim}) return {1'b0, lim - 11'(BOX_SIZE)};
      else                     return {1'b1, pos + 11'(BOX_SPEED)};
    end else begin
      if (pos < 11'(BOX_SPEED)) return {1'b1, 11'd0};
      else                      return {1'b0, pos - 11'(BOX_SPEED)};
    end
  endfunction

  assign w_x_step = step(r_bx, r_dx, act_w(res));
  assign w_y_step = step(r_by, r_dy, act_h(res));

  always_comb begin
    w_bx_nxt  = r_bx;
    w_by_nxt  = r_by;
    w_dx_nxt  = r_dx;
    w_dy_nxt  = r_dy;
    w_res_nxt = r_res;
    if (tick) begin
      w_res_nxt = res;
      if (res != r_res) begin
        w_bx_nxt = 11'd0;
        w_by_nxt = 11'd0;
        w_dx_nxt = DIR_INC;
        w_dy_nxt = DIR_INC;
      end else begin
        w_bx_nxt = w_x_step[10:0];
        w_dx_nxt = dir_e'(w_x_step[11]);
        w_by_nxt = w_y_step[10:0];
        w_dy_nxt = dir_e'(w_y_step[11]);
      end
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_bx  <= 11'd0;
      r_by  <= 11'd0;
      r_dx  <= DIR_INC;
      r_dy  <= DIR_INC;
      r_res <= 2'd0;
    end else begin
      r_bx  <= w_bx_nxt;
      r_by  <= w_by_nxt;
      r_dx  <= w_dx_nxt;
      r_dy  <= w_dy_nxt;
      r_res <= w_res_nxt;
    end
  end

  assign bx = r_bx;
  assign by = r_by;

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern generator, two-stage pixel pipeline.
//   clk_pix, rst_pix        : pixel clock, async active-high reset
//   res, pat                : resolution code, pattern select
//   sx, sy                  : current pixel coordinates
//   hsync_in, vsync_in, de_in : timing strobes (syncs active-low)
//   r, g, b                 : 8-bit colour, zero outside the active area
//   hsync, vsync, de        : strobes delayed 2 cycles to match r/g/b
module pattern_gen
  import video_pkg::*;
#(
  parameter int BOX_SIZE  = 64,
  parameter int BOX_SPEED = 2
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic [1:0]  res,
  input  logic [1:0]  pat,
  input  logic [19:0] sx,
  input  logic [19:0] sy,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        de
);

  logic        r_tick;
  logic [10:0] w_bx, w_by;
  logic [7:0]  r_bar_cnt, w_bar_cnt;
  logic [2:0]  r_bar_idx, w_bar_idx;
  logic        w_hit;
  logic [20:0] w_sx_e, w_sy_e, w_bx_e, w_by_e;

  logic [19:0] r_sx_p1, r_sy_p1;
  logic        r_de_p1, r_hs_p1, r_vs_p1, r_hit_p1;
  logic [1:0]  r_pat_p1, r_res_p1;
  logic [2:0]  r_idx_p1;
  logic        w_grid_line;
  logic [23:0] w_rgb, r_rgb_p2;
  logic        r_de_p2, r_hs_p2, r_vs_p2;

  // The frame tick is the cycle after the origin pixel is presented, so the
  // box moves after pixel (0,0) has been hit-tested with the old position.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) r_tick <= 1'b0;
    else         r_tick <= (sx == 20'd0) && (sy == 20'd0);
  end

  box_mover #(
    .BOX_SIZE (BOX_SIZE),
    .BOX_SPEED(BOX_SPEED)
  ) u_box (
    .clk_pix(clk_pix),
    .rst_pix(rst_pix),
    .tick   (r_tick),
    .res    (res),
    .bx     (w_bx),
    .by     (w_by)
  );

  // Bar index/counter describe the pixel currently on sx; sx==0 restarts them.
  assign w_bar_cnt = (sx == 20'd0) ? 8'd0 : r_bar_cnt;
  assign w_bar_idx = (sx == 20'd0) ? 3'd0 : r_bar_idx;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_bar_cnt <= 8'd0;
      r_bar_idx <= 3'd0;
    end else if (w_bar_cnt == bar_w(res) - 8'd1) begin
      r_bar_cnt <= 8'd0;
      r_bar_idx <= (w_bar_idx == 3'd7) ? 3'd7 : w_bar_idx + 3'd1;
    end else begin
      r_bar_cnt <= w_bar_cnt + 8'd1;
      r_bar_idx <= w_bar_idx;
    end
  end

  assign w_sx_e = {1'b0, sx};
  assign w_sy_e = {1'b0, sy};
  assign w_bx_e = {10'd0, w_bx};
  assign w_by_e = {10'd0, w_by};
  assign w_hit  = (w_sx_e >= w_bx_e) && (w_sx_e < w_bx_e + 21'(BOX_SIZE)) &&
                  (w_sy_e >= w_by_e) && (w_sy_e < w_by_e + 21'(BOX_SIZE));

  // ---- stage 1: capture coordinates, strobes, bar index and box hit ----
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_sx_p1  <= 20'd0;
      r_sy_p1  <= 20'd0;
      r_de_p1  <= 1'b0;
      r_hs_p1  <= 1'b1;
      r_vs_p1  <= 1'b1;
      r_pat_p1 <= 2'd0;
      r_res_p1 <= 2'd0;
      r_idx_p1 <= 3'd0;
      r_hit_p1 <= 1'b0;
    end else begin
      r_sx_p1  <= sx;
      r_sy_p1  <= sy;
      r_de_p1  <= de_in;
      r_hs_p1  <= hsync_in;
      r_vs_p1  <= vsync_in;
      r_pat_p1 <= pat;
      r_res_p1 <= res;
      r_idx_p1 <= w_bar_idx;
      r_hit_p1 <= w_hit;
    end
  end

  assign w_grid_line = (r_sx_p1[5:0] == 6'd0) || (r_sy_p1[5:0] == 6'd0) ||
                       (r_sx_p1 == {9'd0, act_w(r_res_p1)} - 20'd1) ||
                       (r_sy_p1 == {9'd0, act_h(r_res_p1)} - 20'd1);

  always_comb begin
    w_rgb = BLACK;
    case (pat_e'(r_pat_p1))
      PAT_BARS:  w_rgb = bar_colour(r_idx_p1);
      PAT_CHECK: w_rgb = (r_sx_p1[5] ^ r_sy_p1[5]) ? WHITE : BLACK;
      PAT_BOX:   w_rgb = r_hit_p1 ? RED : BOX_BG;
      PAT_GRID:  w_rgb = w_grid_line ? WHITE : DARK_GREY;
      default:   w_rgb = BLACK;
    endcase
    if (!r_de_p1) w_rgb = BLACK;
  end

  // ---- stage 2: registered colour and aligned strobes ----
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_rgb_p2 <= 24'd0;
      r_de_p2  <= 1'b0;
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= 1'b1;
    end else begin
      r_rgb_p2 <= w_rgb;
      r_de_p2  <= r_de_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
    end
  end

  assign r     = r_rgb_p2[23:16];
  assign g     = r_rgb_p2[15:8];
  assign b     = r_rgb_p2[7:0];
  assign hsync = r_hs_p2;
  assign vsync = r_vs_p2;
  assign de    = r_de_p2;

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Pixel-pipeline stage directly downstream of `scrn_pos`. Consumes its screen coordinates and timing strobes, and produces 8-bit RGB for a selectable test pattern. The pattern set is colour bars, checkerboard, bouncing box and grid. Sync and data-enable are re-timed so they stay aligned with the pixel data handed to the output encoder.

## Interface
- `BOX_SIZE`, default 64: bouncing-box side length in pixels; must be ≤ 480.
- `BOX_SPEED`, default 2: box displacement per frame, pixels per axis; 1..15.
- `clk_pix` in 1: pixel clock; sole clock domain.
- `rst_pix` in 1: reset, asynchronous, active-high.
- `res` in 2: resolution code, the same encoding as `scrn_pos`.
  - 0 = 640x480; 1 = 1920x1080; 2 = 1280x720; 3 behaves as 0.
- `pat` in 2: pattern select.
  - 0 = colour bars; 1 = checkerboard; 2 = bouncing box; 3 = grid.
- `sx`, `sy` in 20 each: current pixel coordinates.
- `hsync_in`, `vsync_in` in 1 each: active-low syncs.
- `de_in` in 1: data enable.
- `r`, `g`, `b` out 8 each: pixel colour.
- `hsync`, `vsync`, `de` out 1 each: delayed copies of the inputs.

## Operation
- Active size from `res` (W x H): 640x480, 1920x1080, 1280x720.
- Bar width BW from `res`: 80, 240, 160 respectively.
- Colour bars:
  - Eight bars, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  - Each colour component is FF or 00.
  - Bars are generated by a bar index (3 bit) plus an in-bar counter, not by division.
  - When `sx`==0, both the index and the counter clear.
  - When the counter equals BW-1, it clears and the index increments.
  - The index saturates at 7.
- Checkerboard: white if `sx[5]`^`sy[5]`, else black (32x32 squares).
- Grid:
  - Pixel is white if `sx[5:0]`==0, `sy[5:0]`==0, `sx`==W-1 or `sy`==H-1.
  - Otherwise dark grey 20/20/20.
- Bouncing box:
  - Pixel is red FF/00/00 if bx ≤ `sx` < bx+BOX_SIZE and by ≤ `sy` < by+BOX_SIZE.
  - Otherwise blue 00/00/80.
- Box motion (`box_mover`):
  - Position registers bx, by (11 bit); direction bits dx, dy (1 = increasing).
  - Updates only on the frame tick: the cycle after the inputs show `sx`==0 and `sy`==0.
  - Runs regardless of `pat`.
  - X axis, dx=1: if bx+BOX_SPEED+BOX_SIZE ≥ W, then bx ← W-BOX_SIZE and dx ← 0; else bx ← bx+BOX_SPEED.
  - X axis, dx=0: if bx < BOX_SPEED, then bx ← 0 and dx ← 1; else bx ← bx-BOX_SPEED.
  - Y axis: identical rules using by, dy and H.
  - `res` is sampled at every frame tick. If it differs from the previous tick's value, that tick sets bx=by=0 and dx=dy=1 instead of moving.
- Blanking: when the delayed `de` is 0, r=g=b=0 regardless of pattern.
- `pat` and `res` may change at any cycle. Output may be mixed for one line; no other requirement applies.

## Timing
- Two-stage pipeline; total latency exactly 2 `clk_pix` cycles.
- Stage 1 registers: `sx`, `sy`, `de_in`, `hsync_in`, `vsync_in`, `pat`, the bar index and the box-hit flag.
- Stage 2 registers the colour mux into `r`/`g`/`b`.
- `hsync`/`vsync`/`de` at cycle t+2 equal `hsync_in`/`vsync_in`/`de_in` at cycle t.
- Box position used for hit testing changes only at the frame tick. It is therefore stable throughout the active region.
- Reset values, asserted asynchronously and held while `rst_pix`=1:
  - r=g=b=0, hsync=1, vsync=1, de=0.
  - All pipeline registers cleared, with syncs at 1.
  - bx=by=0, dx=dy=1, bar index 0, stored `res` = 0.
- After deassertion, the first valid outputs appear 2 cycles after the first sampled input.
- Reset mid-frame: the position state restarts at the origin; no partial update.

## Structure
- Shared package `video_pkg` holds:
  - Resolution code enum.
  - Pattern code enum.
  - Per-resolution W, H and BW constant functions.
  - Colour constants (white, yellow, ..., DARK_GREY).
- Sub-module `box_mover`:
  - Inputs: `clk_pix`, `rst_pix`, frame tick, `res`.
  - Outputs: bx, by.
  - Parameters: BOX_SIZE, BOX_SPEED.
  - Holds the direction FSM and the `res`-change detection.

## Test plan
- Latency: drive res=0 timing, pat=1; toggle `de_in` at sx=5. Expect `de` to toggle at the corresponding cycle +2, and `hsync`/`vsync` similarly delayed by 2.
- Colour bars, res=2: `sx`=159 → r/g/b FF/FF/FF; `sx`=160 → FF/FF/00; `sx`=1279 → 00/00/00. Also check blanked `sx`=1300 → 0.
- Checkerboard: (`sx`,`sy`)=(32,0) → FF/FF/FF; (32,32) → 00/00/00; (0,0) → 00/00/00.
- Bounce, res=0, defaults:
  - After 3 frames, bx=by=6.
  - Right wall: after frame 288, bx=576 and dx=0; frame 289 gives bx=574.
  - Bottom wall: frame 208 gives by=416 and dy=0.
- `res` change 0→1 mid-frame: the next frame tick forces bx=by=0. The following tick gives bx=2.
- Asynchronous reset mid-line:
  - Assert `rst_pix` between clock edges: outputs go immediately to 0/1/1/0 (rgb, hsync, vsync, de).
  - After release, bx=0 and outputs track the input after 2 cycles.
